// File: rtl/switch_pkg.sv
// Shared types and defaults for the switch/LED front end.
// Mode encoding selects how a debounced switch drives its LED.
package switch_pkg;
   typedef enum logic [1:0] {
      MODE_TOG_REL = 2'b00,
      MODE_TOG_PRS = 2'b01,
      MODE_FOLLOW  = 2'b10,
      MODE_INVERT  = 2'b11
   } mode_t;

   localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;
endpackage

// File: rtl/switch_toggle_bank_if.sv
// Board-side bundle of switch inputs, mode selects and LED/status outputs.
// The master drives switches and modes; the slave returns the results.
interface switch_toggle_bank_if #(
   parameter int NUM_CH = 4
);
   logic [NUM_CH-1:0]   sw;
   logic [2*NUM_CH-1:0] mode;
   logic [NUM_CH-1:0]   led;
   logic [NUM_CH-1:0]   stable;
   logic [NUM_CH-1:0]   press_pulse;
   logic [NUM_CH-1:0]   release_pulse;

   modport master (
      output sw, mode,
      input  led, stable, press_pulse, release_pulse
   );

   modport slave (
      input  sw, mode,
      output led, stable, press_pulse, release_pulse
   );
endinterface

// File: rtl/switch_debounce.sv
// One channel: 2-FF synchroniser, consecutive-sample debounce filter,
// and rise/fall detection of the committed level.
module switch_debounce
   import switch_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic stable,
   output logic rise,
   output logic fall
);
   localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

   logic             sync1;
   logic             sync2;
   logic             stable_d;
   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         stable   <= 1'b0;
         stable_d <= 1'b0;
         count    <= '0;
      end else begin
         sync1    <= raw;
         sync2    <= sync1;
         stable_d <= stable;
         // any return to the committed level discards the partial run
         if (sync2 == stable) begin
            count <= '0;
         end else if (count == LAST) begin
            stable <= sync2;
            count  <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

   assign rise = stable & ~stable_d;
   assign fall = ~stable & stable_d;
endmodule

// File: rtl/switch_toggle_bank.sv
// Multi-channel switch front end: per-channel debounce plus a mode mux
// choosing toggle-on-release, toggle-on-press, follow or inverted follow.
module switch_toggle_bank
   import switch_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
   input  logic                i_Clk,
   input  logic                i_Reset,
   input  logic [NUM_CH-1:0]   i_Switch,
   input  logic [2*NUM_CH-1:0] i_Mode,
   output logic [NUM_CH-1:0]   o_LED,
   output logic [NUM_CH-1:0]   o_Stable,
   output logic [NUM_CH-1:0]   o_Press_Pulse,
   output logic [NUM_CH-1:0]   o_Release_Pulse
);
   logic [NUM_CH-1:0] stable;
   logic [NUM_CH-1:0] rise;
   logic [NUM_CH-1:0] fall;
   logic [NUM_CH-1:0] tog;
   logic [NUM_CH-1:0] tog_next;
   logic [NUM_CH-1:0] led_next;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      switch_debounce #(
         .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
      ) u_db (
         .clk    (i_Clk),
         .rst    (i_Reset),
         .raw    (i_Switch[c]),
         .stable (stable[c]),
         .rise   (rise[c]),
         .fall   (fall[c])
      );
   end

   // follow modes leave the toggle state untouched so it can resume later
   always_comb begin
      tog_next = tog;
      led_next = tog;
      for (int c = 0; c < NUM_CH; c++) begin
         unique case (mode_t'(i_Mode[2*c +: 2]))
            MODE_TOG_REL: begin
               tog_next[c] = tog[c] ^ fall[c];
               led_next[c] = tog_next[c];
            end
            MODE_TOG_PRS: begin
               tog_next[c] = tog[c] ^ rise[c];
               led_next[c] = tog_next[c];
            end
            MODE_FOLLOW: led_next[c] = stable[c];
            MODE_INVERT: led_next[c] = ~stable[c];
         endcase
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         tog             <= '0;
         o_LED           <= '0;
         o_Press_Pulse   <= '0;
         o_Release_Pulse <= '0;
      end else begin
         tog             <= tog_next;
         o_LED           <= led_next;
         o_Press_Pulse   <= rise;
         o_Release_Pulse <= fall;
      end
   end

   assign o_Stable = stable;
endmodule
